ov7670_cfg_sequencer: RTL and testbench
=======================================

# ov7670_cfg_sequencer

Walks the OV7670 register-configuration ROM from index 0 and turns each 16-bit entry into one SCCB register write. It sits between the configuration ROM, which it addresses and reads, and the SCCB write master, which it drives through a request/ready/done handshake. It honours the ROM's delay and end markers, retries NACKed writes, and reports completion or failure to the camera bring-up logic.

## Interface
- `CLK_HZ`, default 100_000_000: clock frequency, used to derive the millisecond tick.
- `DELAY_MS`, default 10: wait time, in ms, for a delay entry (16'hFFF0).
- `RETRY_MAX`, default 3: number of re-sends of a NACKed entry before declaring an error.
- `clk`  in  1: single clock for the block.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: starts a configuration run. Sampled only in IDLE, DONE and ERROR.
- `rom_addr`  out  8: ROM index.
- `rom_data`  in  16: ROM entry, combinational from `rom_addr`. [15:8] is the register, [7:0] is the value.
- `wr_req`  out  1: write request. Held high until accepted.
- `wr_reg`  out  8: register address. Stable while `wr_req` is high.
- `wr_val`  out  8: register value. Stable while `wr_req` is high.
- `wr_ready`  in  1: the master can accept a request.
- `wr_done`  in  1: one-cycle pulse when the write completes.
- `wr_nack`  in  1: NACK status. Valid only with `wr_done`.
- `busy`  out  1: a run is in progress.
- `cfg_done`  out  1: sticky flag, the run ended at the end marker.
- `cfg_error`  out  1: sticky flag, retries were exhausted.

## Operation
- States:
  - IDLE
  - FETCH: `rom_addr` is stable; `rom_data` is registered into `entry`.
  - DECODE
  - WRITE_REQ
  - WRITE_WAIT
  - DELAY
  - DONE
  - ERROR
- IDLE/DONE/ERROR + `start`:
  - Clear `rom_addr`, the retry count, `cfg_done` and `cfg_error`.
  - Go to FETCH.
- FETCH → DECODE, always.
- DECODE:
  - `entry`==16'hFFFF → DONE.
  - `entry`==16'hFFF0 → DELAY; the delay counter loads DELAY_MS.
  - Any other entry → WRITE_REQ, with `wr_reg`/`wr_val` loaded from `entry`.
- WRITE_REQ:
  - `wr_req`=1.
  - On a clock edge with `wr_req`&`wr_ready` high: go to WRITE_WAIT and deassert `wr_req`.
- WRITE_WAIT, on `wr_done`:
  - `!wr_nack`: clear the retry count, `rom_addr`+1, go to FETCH.
  - `wr_nack` with retry count < RETRY_MAX: retry count +1, go to WRITE_REQ. The same reg/val is resent.
  - `wr_nack` with retry count == RETRY_MAX: go to ERROR. `rom_addr` holds the failing index.
- `wr_done` outside WRITE_WAIT is ignored.
- DELAY:
  - A ms-tick prescaler counts CLK_HZ/1000 cycles per tick.
  - The delay counter decrements once per tick.
  - When it reaches 0: `rom_addr`+1, go to FETCH.
- Wrap-around: a successful write at index 255 goes to DONE. `rom_addr` stays at 255 and never wraps to 0.
- DONE: `cfg_done`=1. ERROR: `cfg_error`=1. Both flags stay set until the next `start` or reset.
- `busy`=1 in every state except IDLE, DONE and ERROR.
- `start` while `busy`=1 is ignored.

## Timing
- Reset values:
  - state=IDLE
  - `rom_addr`=0
  - `wr_req`=0, `wr_reg`=0, `wr_val`=0
  - `busy`=0, `cfg_done`=0, `cfg_error`=0
  - counters=0
- Reset is asynchronous and takes effect mid-transaction: `wr_req` drops immediately and no write is reissued after reset.
- Latency, with `start` sampled at edge N:
  - FETCH at N+1.
  - DECODE at N+2.
  - WRITE_REQ at N+3, i.e. `wr_req` first high in the cycle after edge N+2.
- Per-entry overhead: 3 cycles (FETCH, DECODE, one WRITE_REQ cycle) plus master time.
- Delay entry duration: DELAY_MS×CLK_HZ/1000 cycles, ±1 tick period. The prescaler is cleared on entry to DELAY.
- `wr_reg` and `wr_val` must not change between entering WRITE_REQ and leaving WRITE_WAIT.
- `wr_ready` and `wr_done` asserted in the same cycle in WRITE_REQ: only the acceptance is acted on.

## Structure
- Package `ov7670_cfg_pkg` holds:
  - ROM_END=16'hFFFF
  - ROM_DELAY=16'hFFF0
  - the state encoding
- Sub-module `cfg_ms_timer`: the ms prescaler plus a loadable down-counter, with `load`, `count_in` and `expired`.

## Test plan
Test parameters: CLK_HZ=1000 (1 cycle per ms), DELAY_MS=10, RETRY_MAX=3. Stub ROM, and a stub master whose `wr_ready` and `wr_done` latency are programmable.

- Basic run:
  - ROM = {1280, 1214, FFFF}, `start` pulse.
  - Expect writes (12,80) then (12,14), then `cfg_done`=1 and `busy`=0.
  - `wr_req` first high 3 cycles after `start`.
- Delay entry:
  - ROM = {1280, FFF0, 1214, FFFF}.
  - The gap between `wr_done` of the first write and `wr_req` of the second is 10 cycles + 3 cycles overhead, ±1 cycle.
- NACK then ACK:
  - The first two `wr_done` carry `wr_nack`=1.
  - Expect (12,80) sent 3 times in total, then the run advances; `cfg_error`=0.
- NACK exhaustion:
  - Every `wr_done` at index 5 is NACKed.
  - Expect 4 attempts, `cfg_error`=1, `rom_addr`=5, `busy`=0.
  - A following `start` clears `cfg_error` and restarts from `rom_addr`=0.
- Reset mid-run:
  - Assert `rst_n`=0 during WRITE_WAIT.
  - All outputs return to reset values immediately; no `wr_req` appears until the next `start`.
- No end marker:
  - 256 write entries.
  - Expect 256 writes, then `cfg_done`=1 with `rom_addr`=255; no index-0 write is reissued.

Source files
------------

// File: rtl/ov7670_cfg_pkg.sv
// Shared constants and state encoding for the OV7670 configuration sequencer.
// The ROM markers live here so the ROM builder and the sequencer agree on them.
package ov7670_cfg_pkg;

    localparam logic [15:0] ROM_END   = 16'hFFFF;
    localparam logic [15:0] ROM_DELAY = 16'hFFF0;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_FETCH      = 3'd1,
        S_DECODE     = 3'd2,
        S_WRITE_REQ  = 3'd3,
        S_WRITE_WAIT = 3'd4,
        S_DELAY      = 3'd5,
        S_DONE       = 3'd6,
        S_ERROR      = 3'd7
    } state_t;

endpackage

// File: rtl/ov7670_cfg_sequencer_timer.sv
// Millisecond prescaler plus a loadable down-counter of milliseconds.
// expired is high when the count is zero or will reach zero on this cycle's tick.
module cfg_ms_timer #(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] count_in,
    output logic        expired
);

    localparam int TICK_CYCLES = (CLK_HZ / 1000 > 1) ? CLK_HZ / 1000 : 1;
    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_CYCLES - 1);

    logic [PW-1:0] presc;
    logic [15:0]   count;
    logic          tick;

    assign tick = (presc == TICK_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            count <= 16'd0;
        end else if (load) begin
            presc <= '0;
            count <= count_in;
        end else if (count != 16'd0) begin
            if (tick) begin
                presc <= '0;
                count <= count - 16'd1;
            end else begin
                presc <= presc + PW'(1);
            end
        end
    end

    // Looking one tick ahead lets the FSM leave DELAY on the final tick edge.
    assign expired = (count == 16'd0) || ((count == 16'd1) && tick);

endmodule

// File: rtl/ov7670_cfg_sequencer.sv
// Walks the OV7670 configuration ROM and issues one SCCB write per entry,
// honouring delay/end markers and retrying NACKed writes up to RETRY_MAX times.
module ov7670_cfg_sequencer
    import ov7670_cfg_pkg::*;
#(
    parameter int CLK_HZ    = 100_000_000,
    parameter int DELAY_MS  = 10,
    parameter int RETRY_MAX = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [7:0]  rom_addr,
    input  logic [15:0] rom_data,
    output logic        wr_req,
    output logic [7:0]  wr_reg,
    output logic [7:0]  wr_val,
    input  logic        wr_ready,
    input  logic        wr_done,
    input  logic        wr_nack,
    output logic        busy,
    output logic        cfg_done,
    output logic        cfg_error,
    output logic [2:0]  fsm_state
);

    localparam logic [7:0]  RETRY_LIM = 8'(RETRY_MAX);
    localparam logic [15:0] DELAY_CNT = 16'(DELAY_MS);

    // Write handshake: a request is transferred on a clock edge where
    // wr_req and wr_ready are both high; wr_reg/wr_val hold from WRITE_REQ
    // entry until WRITE_WAIT exits, and wr_done/wr_nack count only in WRITE_WAIT.

    state_t      state, state_next;
    logic [7:0]  addr_next;
    logic [7:0]  retry_cnt, retry_next;
    logic [15:0] entry, entry_next;
    logic [7:0]  reg_next, val_next;
    logic        timer_load;
    logic        timer_expired;

    cfg_ms_timer #(
        .CLK_HZ(CLK_HZ)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .count_in (DELAY_CNT),
        .expired  (timer_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            rom_addr  <= 8'd0;
            retry_cnt <= 8'd0;
            entry     <= 16'd0;
            wr_reg    <= 8'd0;
            wr_val    <= 8'd0;
        end else begin
            state     <= state_next;
            rom_addr  <= addr_next;
            retry_cnt <= retry_next;
            entry     <= entry_next;
            wr_reg    <= reg_next;
            wr_val    <= val_next;
        end
    end

    always_comb begin
        state_next = state;
        addr_next  = rom_addr;
        retry_next = retry_cnt;
        entry_next = entry;
        reg_next   = wr_reg;
        val_next   = wr_val;
        timer_load = 1'b0;

        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    addr_next  = 8'd0;
                    retry_next = 8'd0;
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                entry_next = rom_data;
                state_next = S_DECODE;
            end
            S_DECODE: begin
                if (entry == ROM_END) begin
                    state_next = S_DONE;
                end else if (entry == ROM_DELAY) begin
                    timer_load = 1'b1;
                    state_next = S_DELAY;
                end else begin
                    reg_next   = entry[15:8];
                    val_next   = entry[7:0];
                    state_next = S_WRITE_REQ;
                end
            end
            S_WRITE_REQ: begin
                if (wr_ready) begin
                    state_next = S_WRITE_WAIT;
                end
            end
            S_WRITE_WAIT: begin
                if (wr_done) begin
                    if (!wr_nack) begin
                        retry_next = 8'd0;
                        // Index 255 is the last ROM slot; finish instead of wrapping.
                        if (rom_addr == 8'hFF) begin
                            state_next = S_DONE;
                        end else begin
                            addr_next  = rom_addr + 8'd1;
                            state_next = S_FETCH;
                        end
                    end else if (retry_cnt < RETRY_LIM) begin
                        retry_next = retry_cnt + 8'd1;
                        state_next = S_WRITE_REQ;
                    end else begin
                        state_next = S_ERROR;
                    end
                end
            end
            S_DELAY: begin
                if (timer_expired) begin
                    if (rom_addr == 8'hFF) begin
                        state_next = S_DONE;
                    end else begin
                        addr_next  = rom_addr + 8'd1;
                        state_next = S_FETCH;
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign wr_req    = (state == S_WRITE_REQ);
    assign busy      = (state != S_IDLE) && (state != S_DONE) && (state != S_ERROR);
    assign cfg_done  = (state == S_DONE);
    assign cfg_error = (state == S_ERROR);
    assign fsm_state = state;

endmodule

// File: tb/tb_ov7670_cfg_sequencer.sv
// Directed and randomized bench for ov7670_cfg_sequencer with a stub ROM,
// a stub SCCB master with random latencies, and a ROM-walk reference model.
module tb_ov7670_cfg_sequencer;
    import ov7670_cfg_pkg::*;

    localparam int TB_CLK_HZ    = 1000;
    localparam int TB_DELAY_MS  = 10;
    localparam int TB_RETRY_MAX = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    logic        start = 1'b0;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic        wr_req;
    logic [7:0]  wr_reg;
    logic [7:0]  wr_val;
    logic        wr_ready = 1'b0;
    logic        wr_done = 1'b0;
    logic        wr_nack = 1'b0;
    logic        busy;
    logic        cfg_done;
    logic        cfg_error;
    logic [2:0]  fsm_state;

    logic [15:0] rom [0:255];
    assign rom_data = rom[rom_addr];

    ov7670_cfg_sequencer #(
        .CLK_HZ    (TB_CLK_HZ),
        .DELAY_MS  (TB_DELAY_MS),
        .RETRY_MAX (TB_RETRY_MAX)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .wr_req    (wr_req),
        .wr_reg    (wr_reg),
        .wr_val    (wr_val),
        .wr_ready  (wr_ready),
        .wr_done   (wr_done),
        .wr_nack   (wr_nack),
        .busy      (busy),
        .cfg_done  (cfg_done),
        .cfg_error (cfg_error),
        .fsm_state (fsm_state)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int failures = 0;
    logic [15:0] exp_q[$];
    bit          nack_q[$];
    int          rise_q[$];
    int          done_q[$];
    int          extra_writes = 0;
    logic        exp_done, exp_error;
    logic [7:0]  exp_addr;
    int          start_edge = 0;
    int          lat_max = 0;
    bit          spurious = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_range(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert (obs >= lo && obs <= hi) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // ---------------- stub SCCB master ----------------
    int          m_phase = 0;
    int          m_lat = 0;
    bit          m_cap_valid = 1'b0;
    logic [15:0] m_cap = 16'd0;

    always @(negedge clk) begin
        wr_done = 1'b0;
        wr_nack = 1'b0;
        if (!rst_n) begin
            m_phase = 0;
            wr_ready = 1'b0;
            m_cap_valid = 1'b0;
        end else begin
            case (m_phase)
                0: if (wr_req) begin
                    if (!m_cap_valid) begin
                        m_cap = {wr_reg, wr_val};
                        m_cap_valid = 1'b1;
                        m_lat = $urandom_range(0, lat_max);
                    end else begin
                        chk("wr_stable_req", {wr_reg, wr_val}, m_cap);
                    end
                    if (m_lat == 0) begin
                        wr_ready = 1'b1;
                        // A done pulse alongside acceptance must be ignored.
                        if (spurious) begin
                            wr_done = 1'b1;
                            wr_nack = 1'b1;
                        end
                        if (exp_q.size() > 0) chk("write_data", m_cap, exp_q.pop_front());
                        else extra_writes++;
                        m_phase = 1;
                    end else begin
                        m_lat--;
                    end
                end
                1: begin
                    wr_ready = 1'b0;
                    chk("req_drop_after_accept", wr_req, 1'b0);
                    chk("wr_stable_wait", {wr_reg, wr_val}, m_cap);
                    m_lat = $urandom_range(0, lat_max);
                    m_phase = 2;
                end
                default: begin
                    chk("wr_stable_wait", {wr_reg, wr_val}, m_cap);
                    if (m_lat == 0) begin
                        wr_done = 1'b1;
                        wr_nack = (nack_q.size() > 0) ? nack_q.pop_front() : 1'b0;
                        done_q.push_back(cyc + 1);
                        m_cap_valid = 1'b0;
                        m_phase = 0;
                    end else begin
                        m_lat--;
                    end
                end
            endcase
        end
    end

    // Record the edge on which wr_req is first raised for each request.
    bit req_prev = 1'b0;
    always @(negedge clk) begin
        if (wr_req && !req_prev) rise_q.push_back(cyc);
        req_prev = wr_req;
    end

    // ---------------- reference model ----------------
    // Walks the ROM as the camera bring-up sees it: one write per entry,
    // retries for NACKed attempts, skip delays, stop at end/exhaustion/255.
    task automatic build_model(input int nack_first, input int nack_idx);
        int attempts;
        logic [15:0] e;
        bit ok;
        bit nk;
        attempts = 0;
        exp_q.delete();
        nack_q.delete();
        exp_done = 1'b0;
        exp_error = 1'b0;
        exp_addr = 8'd0;
        for (int i = 0; i < 256; i++) begin
            e = rom[i];
            exp_addr = 8'(i);
            if (e == 16'hFFFF) begin
                exp_done = 1'b1;
                return;
            end
            if (e != 16'hFFF0) begin
                ok = 1'b0;
                for (int a = 0; a <= TB_RETRY_MAX; a++) begin
                    nk = (attempts < nack_first) || (i == nack_idx);
                    attempts++;
                    exp_q.push_back(e);
                    nack_q.push_back(nk);
                    if (!nk) begin
                        ok = 1'b1;
                        break;
                    end
                end
                if (!ok) begin
                    exp_error = 1'b1;
                    return;
                end
            end
        end
        exp_done = 1'b1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_tb();
        rise_q.delete();
        done_q.delete();
        extra_writes = 0;
    endtask

    task automatic fill_end();
        for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
    endtask

    function automatic logic [15:0] rand_write();
        logic [7:0] r;
        logic [7:0] v;
        r = 8'($urandom_range(0, 254));
        v = 8'($urandom_range(0, 255));
        return {r, v};
    endfunction

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        start_edge = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1'b1);
    endtask

    task automatic finish_run(input int budget);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("run_completes", (n < budget) ? 1 : 0, 1);
        repeat (3) @(negedge clk);
        chk("cfg_done", cfg_done, exp_done);
        chk("cfg_error", cfg_error, exp_error);
        chk("final_rom_addr", rom_addr, exp_addr);
        chk("busy_idle", busy, 1'b0);
        chk("wr_req_idle", wr_req, 1'b0);
        chk("writes_outstanding", exp_q.size(), 0);
        chk("extra_writes", extra_writes, 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        int nf;
        int len;
        fill_end();

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_state", fsm_state, S_IDLE);
        chk("rst_rom_addr", rom_addr, 8'd0);
        chk("rst_outputs", {wr_req, wr_reg, wr_val, busy, cfg_done, cfg_error}, 20'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic run
        clear_tb();
        rom[0] = 16'h1280; rom[1] = 16'h1214; rom[2] = 16'hFFFF;
        build_model(0, -1);
        do_start();
        finish_run(2000);
        chk("basic_req_count", rise_q.size(), 2);
        // start sampled at edge N, WRITE_REQ entered at edge N+2 (high in cycle N+3)
        if (rise_q.size() > 0) chk("start_to_req", rise_q[0] - start_edge, 2);

        // Delay entry
        clear_tb();
        lat_max = 2;
        fill_end();
        rom[0] = 16'h1280; rom[1] = 16'hFFF0; rom[2] = 16'h1214; rom[3] = 16'hFFFF;
        build_model(0, -1);
        do_start();
        finish_run(2000);
        chk("delay_req_count", rise_q.size(), 2);
        if (rise_q.size() > 1 && done_q.size() > 0)
            chk_range("delay_gap", rise_q[1] - done_q[0], 12, 14);

        // NACK then ACK
        clear_tb();
        fill_end();
        rom[0] = 16'h1280; rom[1] = 16'h1214; rom[2] = 16'hFFFF;
        build_model(2, -1);
        chk("model_nack_sends", exp_q.size(), 4);
        do_start();
        finish_run(2000);
        chk("nack_ack_req_count", rise_q.size(), 4);

        // NACK exhaustion at index 5, then restart
        clear_tb();
        fill_end();
        for (int i = 0; i < 10; i++) rom[i] = rand_write();
        build_model(0, 5);
        do_start();
        finish_run(4000);
        chk("exhaust_attempts_total", rise_q.size(), 5 + TB_RETRY_MAX + 1);
        chk("exhaust_addr", rom_addr, 8'd5);
        clear_tb();
        build_model(0, -1);
        do_start();
        chk("restart_clears_error", cfg_error, 1'b0);
        chk("restart_addr", rom_addr, 8'd0);
        finish_run(4000);

        // Reset mid-run during WRITE_WAIT of the second write
        clear_tb();
        fill_end();
        for (int i = 0; i < 4; i++) rom[i] = rand_write();
        build_model(0, -1);
        do_start();
        n = 0;
        while (!(done_q.size() >= 1 && m_phase == 2) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("reach_write_wait", (n < 500) ? 1 : 0, 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_wr_req", wr_req, 1'b0);
        chk("async_rst_busy", busy, 1'b0);
        chk("async_rst_addr", rom_addr, 8'd0);
        chk("async_rst_regval", {wr_reg, wr_val}, 16'd0);
        chk("async_rst_flags", {cfg_done, cfg_error}, 2'b00);
        chk("async_rst_state", fsm_state, S_IDLE);
        exp_q.delete();
        nack_q.delete();
        @(negedge clk);
        clear_tb();
        #2 rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("no_req_after_reset", rise_q.size(), 0);
        chk("idle_after_reset", busy, 1'b0);

        // No end marker: 256 writes, stop at 255
        clear_tb();
        lat_max = 1;
        for (int i = 0; i < 256; i++) rom[i] = rand_write();
        build_model(0, -1);
        do_start();
        finish_run(20000);
        repeat (20) @(negedge clk);
        chk("full_rom_req_count", rise_q.size(), 256);
        chk("full_rom_addr", rom_addr, 8'hFF);
        chk("full_rom_no_rewrite", extra_writes, 0);

        // Randomized ROMs with delays, NACKs and spurious dones
        for (int it = 0; it < 4; it++) begin
            clear_tb();
            fill_end();
            len = $urandom_range(5, 10);
            for (int i = 0; i < len; i++)
                rom[i] = (i > 0 && $urandom_range(0, 3) == 0) ? 16'hFFF0 : rand_write();
            nf = $urandom_range(0, TB_RETRY_MAX);
            spurious = 1'($urandom_range(0, 1));
            lat_max = $urandom_range(0, 3);
            build_model(nf, -1);
            do_start();
            finish_run(5000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
